// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one frame per accepted TxStart, pacing each
// bit on the upstream BaudTick pulse. The frame is a start bit, DataBits data
// bits LSB first, an optional parity bit and StopBits stop bits.
module uart_transmitter #(
  parameter int DataBits     = 8,
  parameter int ParityEnable = 0,
  parameter int ParityOdd    = 0,
  parameter int StopBits     = 1
) (
  input  logic       Clock,
  input  logic       MR,
  input  logic       BaudTick,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic       TxReady,
  output logic       TxDone,
  output logic       Busy,
  output logic       TxSerial
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [2:0] LastBit  = 3'(DataBits - 1);
  localparam logic       LastStop = 1'(StopBits - 1);
  localparam logic       OddFlip  = 1'(ParityOdd);

  state_t              state_q, state_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                parity_q, parity_d;
  logic                tx_serial_q, tx_serial_d;
  logic                tx_done_q, tx_done_d;

  // Next-state logic; the line value is computed one cycle ahead so the
  // serial output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    tx_serial_d = tx_serial_q;
    tx_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_serial_d = 1'b1;
        if (TxStart) begin
          shift_d    = TxData[DataBits-1:0];
          parity_d   = (^TxData[DataBits-1:0]) ^ OddFlip;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        tx_serial_d = 1'b1;
        if (BaudTick) begin
          state_d     = START;
          tx_serial_d = 1'b0;
        end
      end
      START: begin
        if (BaudTick) begin
          state_d     = DATA;
          bit_cnt_d   = 3'd0;
          tx_serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (BaudTick) begin
          if (bit_cnt_q == LastBit) begin
            if (ParityEnable != 0) begin
              state_d     = PARITY;
              tx_serial_d = parity_q;
            end else begin
              state_d     = STOP;
              stop_cnt_d  = 1'b0;
              tx_serial_d = 1'b1;
            end
          end else begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            shift_d     = shift_q >> 1;
            tx_serial_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (BaudTick) begin
          state_d     = STOP;
          stop_cnt_d  = 1'b0;
          tx_serial_d = 1'b1;
        end
      end
      STOP: begin
        tx_serial_d = 1'b1;
        if (BaudTick) begin
          if (stop_cnt_q == LastStop) begin
            state_d   = IDLE;
            tx_done_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        tx_serial_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous master reset.
  always_ff @(posedge Clock) begin
    if (MR) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= 3'd0;
      stop_cnt_q  <= 1'b0;
      parity_q    <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      parity_q    <= parity_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign TxReady  = (state_q == IDLE);
  assign Busy     = ~TxReady;
  assign TxDone   = tx_done_q;
  assign TxSerial = tx_serial_q;

endmodule
